varint_decode_fsm: RTL and testbench
====================================

# varint_decode_fsm

Control and datapath FSM for the varint decoder. It pops LEB128-style bytes from the byte input FIFO and reassembles them into 32-bit unsigned words, least-significant 7-bit group first. Each completed word goes to the word output FIFO together with its encoded byte length. It is the receive-side counterpart of the varint encode FSM and sits between the byte-stream ingress FIFO and the field-extraction stage.

## Interface
Parameters:
- MAX_BYTES, 5, maximum encoded length of one word; fixed at 5 for 32-bit values. Not intended to be overridden.

Ports:
- clk  input  1  clock; all logic is on the rising edge
- reset  input  1  synchronous, active-high reset
- byte_fifo_empty  input  1  byte FIFO has no data
- byte_fifo_pop  output  1  consume the head byte; combinational
- byte_data_in  input  8  head byte of the byte FIFO; show-ahead, valid whenever not empty
- word_fifo_full  input  1  word FIFO cannot accept a push
- word_fifo_push  output  1  write word_data_out / word_len_out / decode_error; combinational
- word_data_out  output  32  decoded value; registered
- word_len_out  output  3  number of bytes consumed for this word, 1..5; registered
- decode_error  output  1  qualified by word_fifo_push; word is overlong or overflows 32 bits

## Operation
- Registers:
  - state (one-hot)
  - acc[31:0]: accumulator
  - idx[2:0]: byte index
  - err: error flag
- States: INIT, FETCH, EMIT, DRAIN.
- INIT: entered on reset. Moves to FETCH on the next cycle unconditionally. No pop, no push.
- FETCH:
  - byte_fifo_pop = !byte_fifo_empty. When empty, hold all registers.
  - On a pop, OR byte_data_in[6:0] into acc at bit position 7*idx. Bits above 31 are discarded.
  - Exit conditions on a pop:
    - byte[7]=0 → EMIT with word_len = idx+1.
    - byte[7]=1 and idx<4 → idx++, stay in FETCH.
    - idx=4 and byte[7]=1 → err=1, EMIT, and after the push go to DRAIN.
    - idx=4 and byte[6:4]≠0 → err=1 (32-bit overflow).
- EMIT:
  - word_fifo_push = !word_fifo_full.
  - word_data_out = acc, word_len_out = idx+1, decode_error = err. All three are held stable while word_fifo_full.
  - On a push: clear acc, idx, err. Next state is DRAIN if the overlong flag is set, otherwise FETCH.
  - No pop in EMIT.
- DRAIN:
  - Pops and discards bytes while !empty.
  - The first popped byte with bit7=0 is consumed and the state moves to FETCH.
  - No push in DRAIN. Discarded bytes do not touch acc.
- Pop and push are never asserted in the same cycle.
- A pop is only asserted when the FIFO is not empty; a push only when the word FIFO is not full.
- Reset mid-word:
  - Partial acc, idx, err and any DRAIN in progress are abandoned.
  - All outputs go to their reset values the cycle after reset is sampled.
  - Bytes already popped are lost. Decoding resumes at the current FIFO head.
- Reset values:
  - byte_fifo_pop=0, word_fifo_push=0, decode_error=0 (while in INIT)
  - word_data_out=0, word_len_out=0
  - state=INIT, acc=0, idx=0, err=0

## Timing
- Back-pressure-free throughput is one byte per cycle plus one EMIT cycle per word:
  - 1-byte varint: 2 cycles per word.
  - 5-byte varint: 6 cycles per word.
- Latency: push occurs in the cycle after the terminating byte is popped.
- First pop can occur 2 cycles after reset deasserts (INIT, then FETCH).
- FIFO empty mid-word: FETCH stalls with no pop and no state change. There is no timeout.
- word_fifo_full during EMIT: the FSM stalls indefinitely. Outputs are stable and it does not pop.
- Pop is combinational from state and byte_fifo_empty. Push is combinational from state and word_fifo_full. There is no combinational path from byte_data_in to any output.

## Test plan
- Bytes 0x01 → one push: data 0x00000001, len 1, error 0; push 1 cycle after the pop.
- Bytes 0xAC, 0x02 → data 0x0000012C (300), len 2, error 0.
- Bytes 0xFF, 0xFF, 0xFF, 0xFF, 0x0F → data 0xFFFFFFFF, len 5, error 0. Bytes 0xFF×4, 0x1F → error 1 (overflow), data 0xFFFFFFFF.
- Bytes 0xFF×5, 0x80, 0x01, 0x05 →
  - push data 0xFFFFFFFF, len 5, error 1;
  - 0x80 and 0x01 popped in DRAIN with no push;
  - then push data 0x00000005, len 1, error 0.
- Stream 0x96, 0x01 with word_fifo_full held high for 10 cycles in EMIT → no push, no pop, data 0x00000096 stable. On release: exactly one push of data 0x00000096, len 2.
- Pop 0xFF, 0xFF, then assert reset for 1 cycle, then feed 0x07 → no push from the partial word; single push of data 0x00000007, len 1, error 0.
- Byte FIFO empty between 0xAC and 0x02 for 5 cycles → no pop and no push during the gap; result 0x0000012C.

Source files
------------

// File: rtl/varint_decode_fsm.sv
// LEB128 varint decoder: pops bytes from the byte FIFO, rebuilds 32-bit
// words LSB group first, and pushes word, length and error flag.
module varint_decode_fsm #(
  parameter int MAX_BYTES = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        byte_fifo_empty,
  output logic        byte_fifo_pop,
  input  logic [7:0]  byte_data_in,
  input  logic        word_fifo_full,
  output logic        word_fifo_push,
  output logic [31:0] word_data_out,
  output logic [2:0]  word_len_out,
  output logic        decode_error
);

  typedef enum logic [3:0] {
    INIT  = 4'b0001,
    FETCH = 4'b0010,
    EMIT  = 4'b0100,
    DRAIN = 4'b1000
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] acc_q, acc_d;
  logic [2:0]  idx_q, idx_d;
  logic [2:0]  len_q, len_d;
  logic        err_q, err_d;
  logic        ovl_q, ovl_d;

  logic        last_idx;
  logic [5:0]  shamt;
  logic [31:0] grp;

  assign last_idx = (idx_q == 3'(MAX_BYTES - 1));
  assign shamt    = 6'(idx_q) * 6'd7;
  // Group bits shifted past bit 31 fall off here.
  assign grp      = {25'd0, byte_data_in[6:0]} << shamt;

  always_comb begin
    state_d        = state_q;
    acc_d          = acc_q;
    idx_d          = idx_q;
    len_d          = len_q;
    err_d          = err_q;
    ovl_d          = ovl_q;
    byte_fifo_pop  = 1'b0;
    word_fifo_push = 1'b0;
    unique case (state_q)
      INIT: state_d = FETCH;
      FETCH: begin
        if (!byte_fifo_empty) begin
          byte_fifo_pop = 1'b1;
          acc_d = acc_q | grp;
          if (last_idx && (byte_data_in[6:4] != 3'd0))
            err_d = 1'b1;
          if (!byte_data_in[7]) begin
            len_d   = idx_q + 3'd1;
            state_d = EMIT;
          end else if (!last_idx) begin
            idx_d = idx_q + 3'd1;
          end else begin
            err_d   = 1'b1;
            ovl_d   = 1'b1;
            len_d   = idx_q + 3'd1;
            state_d = EMIT;
          end
        end
      end
      EMIT: begin
        if (!word_fifo_full) begin
          word_fifo_push = 1'b1;
          acc_d   = '0;
          idx_d   = '0;
          len_d   = '0;
          err_d   = 1'b0;
          ovl_d   = 1'b0;
          state_d = ovl_q ? DRAIN : FETCH;
        end
      end
      DRAIN: begin
        if (!byte_fifo_empty) begin
          byte_fifo_pop = 1'b1;
          if (!byte_data_in[7])
            state_d = FETCH;
        end
      end
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= INIT;
      acc_q   <= '0;
      idx_q   <= '0;
      len_q   <= '0;
      err_q   <= 1'b0;
      ovl_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      err_q   <= err_d;
      ovl_q   <= ovl_d;
    end
  end

  assign word_data_out = acc_q;
  assign word_len_out  = len_q;
  assign decode_error  = err_q;

endmodule

// File: tb/tb_varint_decode_fsm.sv
// Scoreboard bench for varint_decode_fsm with a modelled show-ahead
// byte FIFO and a controllable word-FIFO full flag.
module tb_varint_decode_fsm;

  logic        clk = 1'b0;
  logic        reset;
  logic        byte_fifo_empty;
  logic        byte_fifo_pop;
  logic [7:0]  byte_data_in;
  logic        word_fifo_full;
  logic        word_fifo_push;
  logic [31:0] word_data_out;
  logic [2:0]  word_len_out;
  logic        decode_error;

  varint_decode_fsm dut (
    .clk             (clk),
    .reset           (reset),
    .byte_fifo_empty (byte_fifo_empty),
    .byte_fifo_pop   (byte_fifo_pop),
    .byte_data_in    (byte_data_in),
    .word_fifo_full  (word_fifo_full),
    .word_fifo_push  (word_fifo_push),
    .word_data_out   (word_data_out),
    .word_len_out    (word_len_out),
    .decode_error    (decode_error)
  );

  always #5 clk = ~clk;

  logic [7:0]  bq[$];
  logic [31:0] exp_data[$];
  logic [2:0]  exp_len[$];
  logic        exp_err[$];

  int   n_pass = 0;
  int   n_total = 0;
  int   cyc = 0;
  int   last_pop = -100;
  bit   gap = 0;
  bit   lat_chk = 1;
  logic s_pop, s_push;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_total++;
    if (got !== exp)
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    else
      n_pass++;
  endtask

  task automatic drive();
    byte_fifo_empty = gap || (bq.size() == 0);
    byte_data_in    = (bq.size() != 0) ? bq[0] : 8'h00;
  endtask

  task automatic expect_word(logic [31:0] d, logic [2:0] l, logic e);
    exp_data.push_back(d);
    exp_len.push_back(l);
    exp_err.push_back(e);
  endtask

  task automatic cycle();
    @(negedge clk);
    s_pop  = byte_fifo_pop;
    s_push = word_fifo_push;
    if (s_pop)
      check("pop_when_empty", byte_fifo_empty, 0);
    if (s_push) begin
      check("push_when_full", word_fifo_full, 0);
      check("pop_and_push", s_pop, 0);
      if (lat_chk)
        check("push_latency", cyc - last_pop, 1);
      if (exp_data.size() == 0) begin
        check("unexpected_push", word_data_out, 32'hDEAD);
      end else begin
        check("data", word_data_out, exp_data.pop_front());
        check("len", 32'(word_len_out), 32'(exp_len.pop_front()));
        check("err", 32'(decode_error), 32'(exp_err.pop_front()));
      end
    end
    @(posedge clk);
    #1;
    if (s_pop) begin
      last_pop = cyc;
      if (bq.size() != 0) void'(bq.pop_front());
    end
    cyc++;
    drive();
  endtask

  task automatic run_idle();
    int n = 0;
    while ((bq.size() != 0 || exp_data.size() != 0) && n < 300) begin
      cycle();
      n++;
    end
    if (n >= 300) check("timeout", 1, 0);
    repeat (3) cycle();
  endtask

  task automatic feed(logic [7:0] b);
    bq.push_back(b);
    drive();
  endtask

  task automatic enc(logic [31:0] v);
    logic [31:0] t = v;
    logic [7:0]  b;
    int          n = 0;
    do begin
      b = {1'b0, t[6:0]};
      t = t >> 7;
      if (t != 0) b[7] = 1'b1;
      feed(b);
      n++;
    end while (t != 0);
    expect_word(v, 3'(n), 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    word_fifo_full = 1'b0;
    gap = 0;
    drive();
    feed(8'h01);
    repeat (2) cycle();
    @(negedge clk);
    check("rst_pop", byte_fifo_pop, 0);
    check("rst_push", word_fifo_push, 0);
    check("rst_data", word_data_out, 0);
    check("rst_len", 32'(word_len_out), 0);
    check("rst_err", decode_error, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    cycle();
    check("init_no_pop", s_pop, 0);
    cycle();
    check("first_pop", s_pop, 1);
    expect_word(32'h1, 3'd1, 1'b0);
    run_idle();

    feed(8'hAC); feed(8'h02);
    expect_word(32'h12C, 3'd2, 1'b0);
    run_idle();

    repeat (4) feed(8'hFF);
    feed(8'h0F);
    expect_word(32'hFFFFFFFF, 3'd5, 1'b0);
    run_idle();

    repeat (4) feed(8'hFF);
    feed(8'h1F);
    expect_word(32'hFFFFFFFF, 3'd5, 1'b1);
    run_idle();

    repeat (5) feed(8'hFF);
    feed(8'h80); feed(8'h01); feed(8'h05);
    expect_word(32'hFFFFFFFF, 3'd5, 1'b1);
    expect_word(32'h5, 3'd1, 1'b0);
    run_idle();

    word_fifo_full = 1'b1;
    feed(8'h96); feed(8'h01);
    expect_word(32'h96, 3'd2, 1'b0);
    repeat (3) cycle();
    for (int i = 0; i < 10; i++) begin
      cycle();
      check("full_no_push", s_push, 0);
      check("full_no_pop", s_pop, 0);
      check("full_data", word_data_out, 32'h96);
    end
    word_fifo_full = 1'b0;
    lat_chk = 0;
    run_idle();
    lat_chk = 1;

    feed(8'hFF); feed(8'hFF);
    repeat (2) cycle();
    check("partial_popped", bq.size(), 0);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    feed(8'h07);
    expect_word(32'h7, 3'd1, 1'b0);
    run_idle();

    feed(8'hAC); feed(8'h02);
    expect_word(32'h12C, 3'd2, 1'b0);
    cycle();
    gap = 1;
    drive();
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("gap_no_pop", s_pop, 0);
      check("gap_no_push", s_push, 0);
    end
    gap = 0;
    drive();
    run_idle();

    enc(32'h0); enc(32'h7F); enc(32'h80); enc(32'h3FFF);
    enc(32'h4000); enc(32'h0FFFFFFF); enc(32'h10000000);
    for (int i = 0; i < 8; i++) enc($urandom);
    run_idle();

    check("sb_empty", exp_data.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
